// File: rtl/sink_arb_pkg.sv
// Shared types and helpers for the sink arbiter: FSM state encoding and
// the index-width function used to size requester indices.
package sink_arb_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sink_arbiter_if.sv
// Requester-side and sink-side val/rdy bundle of the sink arbiter.
// The arbiter takes the slave view; the harness drives the master view.
interface sink_arbiter_if #(
    parameter int p_width = 16,
    parameter int p_nreqs = 4
);
    logic [p_nreqs-1:0]                         in_val;
    logic [p_nreqs-1:0]                         in_rdy;
    logic [p_nreqs*p_width-1:0]                 in_msg;
    logic                                       out_val;
    logic                                       out_rdy;
    logic [p_width-1:0]                         out_msg;
    logic [sink_arb_pkg::idx_w(p_nreqs)-1:0]    out_src;

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_src
    );

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_src
    );
endinterface

// File: rtl/sink_arbiter_rr_grant.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping modulo p_nreqs. Returns one-hot grant, its index and any-request.
module rr_grant
    import sink_arb_pkg::*;
#(
    parameter  int p_nreqs = 4,
    localparam int IW      = idx_w(p_nreqs)
) (
    input  logic [p_nreqs-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [p_nreqs-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < p_nreqs; k++) begin
            j = (int'(ptr) + k) % p_nreqs;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/sink_arbiter.sv
// Round-robin arbiter sharing one val/rdy sink among p_nreqs requesters,
// with a one-entry output buffer and done after p_nmsgs deliveries.
// Optional stall watchdog with sticky hang output: SINK_ARB_WATCHDOG_EN.
module sink_arbiter
    import sink_arb_pkg::*;
#(
    parameter int p_width   = 16,
    parameter int p_nreqs   = 4,
    parameter int p_nmsgs   = 4,
    parameter int p_timeout = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    sink_arbiter_if.slave    bus,
`ifdef SINK_ARB_WATCHDOG_EN
    output logic             hang,
`endif
    output logic             done
);
    localparam int IW = idx_w(p_nreqs);
    localparam int CW = $clog2(p_nmsgs + 1);

    state_e             state;
    logic [IW-1:0]      ptr;
    logic [CW-1:0]      cnt;
    logic [p_width-1:0] msg_q;
    logic [IW-1:0]      src_q;

    logic [p_nreqs-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               gany;
    logic               can_accept, in_hs, out_hs, last;

    rr_grant #(.p_nreqs(p_nreqs)) u_grant (
        .req   (bus.in_val),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // reset_n gates acceptance so in_rdy stays low while reset is held
    assign can_accept = reset_n &&
                        ((state == ST_EMPTY) || (state == ST_FULL && bus.out_rdy));
    assign in_hs      = can_accept && gany;
    assign out_hs     = (state == ST_FULL) && bus.out_rdy;
    assign last       = out_hs && (cnt == CW'(p_nmsgs - 1));

    assign bus.in_rdy  = can_accept ? grant : '0;
    assign bus.out_val = (state == ST_FULL);
    assign bus.out_msg = msg_q;
    assign bus.out_src = src_q;
    assign done        = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
            ptr   <= '0;
            cnt   <= '0;
            msg_q <= '0;
            src_q <= '0;
        end else begin
            if (out_hs)
                cnt <= cnt + CW'(1);
            if (in_hs)
                ptr <= (gidx == IW'(p_nreqs - 1)) ? '0 : gidx + IW'(1);
            // the final delivery wins over any input accepted alongside it
            if (last) begin
                state <= ST_DONE;
            end else if (in_hs) begin
                state <= ST_FULL;
                msg_q <= bus.in_msg[gidx*p_width +: p_width];
                src_q <= gidx;
            end else if (out_hs) begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef SINK_ARB_WATCHDOG_EN
    localparam int WW = $clog2(p_timeout + 1);
    logic [WW-1:0] wd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd   <= '0;
            hang <= 1'b0;
        end else if (out_hs) begin
            wd <= '0;
        end else if (state != ST_DONE && wd != WW'(p_timeout)) begin
            wd <= wd + WW'(1);
            if (wd == WW'(p_timeout - 1))
                hang <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sink_arbiter.sv
// Self-checking bench for sink_arbiter: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_sink_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int NM = 10;
    localparam int T  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic done;
`ifdef SINK_ARB_WATCHDOG_EN
    logic hang;
`endif

    sink_arbiter_if #(.p_width(W), .p_nreqs(N)) bus ();

    sink_arbiter #(.p_width(W), .p_nreqs(N), .p_nmsgs(NM), .p_timeout(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
`ifdef SINK_ARB_WATCHDOG_EN
        .hang    (hang),
`endif
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: buffered message, priority pointer, delivery count
    bit             m_full, m_done, m_hang;
    int             m_ptr, m_cnt, m_src, m_wd;
    logic [W-1:0]   m_msg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] msg_of(input int i);
        return bus.in_msg[i*W +: W];
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (bus.in_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic bit ready();
        return !m_done && (!m_full || bus.out_rdy);
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = pick();
        if (ready() && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 0; m_done = 0; m_hang = 0;
        m_ptr = 0; m_cnt = 0; m_src = 0; m_wd = 0; m_msg = '0;
    endtask

    task automatic model_step();
        int  g;
        bit  acc, dlv;
        g   = pick();
        acc = ready() && g >= 0;
        dlv = m_full && bus.out_rdy && !m_done;
        if (dlv) m_wd = 0;
        else if (!m_done && m_wd < T) begin
            m_wd++;
            if (m_wd == T) m_hang = 1;
        end
        if (dlv) m_cnt++;
        if (dlv && m_cnt == NM) begin
            m_done = 1; m_full = 0;
        end else if (acc) begin
            m_full = 1; m_msg = msg_of(g); m_src = g;
        end else if (dlv) begin
            m_full = 0;
        end
        if (acc) m_ptr = (g + 1) % N;
    endtask

    task automatic check_outs();
        check("out_val", 32'(bus.out_val), 32'(m_full));
        check("out_msg", 32'(bus.out_msg), 32'(m_msg));
        check("out_src", 32'(bus.out_src), 32'(m_src));
        check("done",    32'(done),        32'(m_done));
        check("in_rdy",  32'(bus.in_rdy),  32'(exp_rdy()));
`ifdef SINK_ARB_WATCHDOG_EN
        check("hang",    32'(hang),        32'(m_hang));
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // assert mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_val", 32'(bus.out_val), 32'd0);
        check("rst_in_rdy",  32'(bus.in_rdy),  32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_out_msg", 32'(bus.out_msg), 32'd0);
        check("rst_out_src", 32'(bus.out_src), 32'd0);
`ifdef SINK_ARB_WATCHDOG_EN
        check("rst_hang",    32'(hang),        32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic rand_msgs();
        for (int i = 0; i < N; i++) bus.in_msg[i*W +: W] = W'($urandom);
    endtask

    initial begin
        bus.in_val  = '0;
        bus.in_msg  = '0;
        bus.out_rdy = 1'b0;
        model_reset();
        do_reset();

        // fairness: all requesters busy, grants rotate 0,1,2,3,...
        bus.in_val  = '1;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < N; i++) bus.in_msg[i*W +: W] = W'(16'h1000 + i);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("fair_src", 32'(bus.out_src), 32'(k % N));
            check("fair_val", 32'(bus.out_val), 32'd1);
        end

        // sparse: only requesters 1 and 3
        do_reset();
        bus.in_val = 4'b1010;
        bus.in_msg = '0;
        bus.in_msg[1*W +: W] = 16'h0011;
        bus.in_msg[3*W +: W] = 16'h0033;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("sparse_src", 32'(bus.out_src), (k == 1) ? 32'd3 : 32'd1);
            check("sparse_msg", 32'(bus.out_msg), (k == 1) ? 32'h33 : 32'h11);
        end

        // backpressure: hold 0xABCD from requester 2
        do_reset();
        bus.in_val = 4'b0100;
        bus.in_msg[2*W +: W] = 16'hABCD;
        cycle();
        bus.in_val  = '1;
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_val", 32'(bus.out_val), 32'd1);
            check("bp_msg", 32'(bus.out_msg), 32'hABCD);
            check("bp_src", 32'(bus.out_src), 32'd2);
            check("bp_rdy", 32'(bus.in_rdy),  32'd0);
        end
        bus.in_val  = '0;
        bus.out_rdy = 1'b1;
        cycle();
        check("bp_drained", 32'(bus.out_val), 32'd0);

        // done after NM deliveries under continuous traffic
        do_reset();
        bus.in_val  = '1;
        bus.out_rdy = 1'b1;
        for (int k = 0; k < NM + 3; k++) begin
            rand_msgs();
            cycle();
        end
        check("done_hi",  32'(done),        32'd1);
        check("done_val", 32'(bus.out_val), 32'd0);
        check("done_rdy", 32'(bus.in_rdy),  32'd0);

        // async reset while FULL, then first grant goes to requester 0
        do_reset();
        bus.in_val  = 4'b1000;
        bus.out_rdy = 1'b0;
        cycle();
        check("pre_rst_full", 32'(bus.out_val), 32'd1);
        do_reset();
        bus.in_val  = '1;
        bus.out_rdy = 1'b1;
        cycle();
        check("post_rst_src", 32'(bus.out_src), 32'd0);

        // random traffic with periodic resets
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) do_reset();
            bus.in_val  = N'($urandom);
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            rand_msgs();
            cycle();
        end

`ifdef SINK_ARB_WATCHDOG_EN
        // stall watchdog: buffered message with sink held off
        do_reset();
        bus.in_val  = 4'b0001;
        bus.out_rdy = 1'b0;
        cycle();
        bus.in_val = '0;
        for (int k = 0; k < 12; k++) cycle();
        check("wd_hang", 32'(hang), 32'd1);
        bus.out_rdy = 1'b1;
        cycle();
        cycle();
        check("wd_sticky", 32'(hang), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
